rx_channel_arbiter: RTL
=======================

RX_CHANNEL_ARBITER -- requirements
Module: rx_channel_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 4, number of receiver channels (2..8).
REQ-002 SHALL have parameter DW, default 8, data width per channel.
REQ-003 SHALL have port bclk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ch_data, input, NCH*DW, received byte per channel; channel i occupies bits [i*DW +: DW].
REQ-006 SHALL have port ch_strobe, input, NCH, one-cycle pulse per channel marking a new byte on ch_data.
REQ-007 SHALL have port out_data, output, DW, granted byte.
REQ-008 SHALL have port out_ch, output, clog2(NCH), index of the granted channel.
REQ-009 SHALL have port out_valid, output, 1, offer to host.
REQ-010 SHALL have port out_ready, input, 1, host accept.
REQ-011 SHALL have port pend, output, NCH, holding slot occupied per channel.
REQ-012 SHALL have port overrun, output, NCH, sticky byte-dropped flag per channel.
REQ-013 SHALL have port ovr_clr, input, NCH, per-channel clear for overrun.

Function
REQ-014 SHALL hold one DW-bit slot per channel; ch_strobe[i] with pend[i]=0 captures ch_data on that edge and sets pend[i] at the next cycle.
REQ-015 SHALL, on ch_strobe[i] with pend[i]=1 and no pop of channel i in that cycle, drop the new byte, keep the old one, and set overrun[i].
REQ-016 SHALL, on ch_strobe[i] in the same cycle as a pop of channel i, capture the new byte, keep pend[i]=1, and leave overrun[i] unchanged.
REQ-017 SHALL use a two-state FSM: IDLE and OFFER.
REQ-018 SHALL, in IDLE with any pend bit set, select the first pending channel searching upward from last_grant+1 modulo NCH, register the slot into out_data and the index into out_ch, and enter OFFER.
REQ-019 SHALL, in IDLE with no pend bit set, remain in IDLE with out_valid=0.
REQ-020 SHALL assert out_valid exactly while in OFFER, holding out_data and out_ch stable until the handshake.
REQ-021 SHALL complete a pop on the edge where out_valid=1 and out_ready=1: clear the granted pend bit (except as in REQ-016), update last_grant to out_ch, and return to IDLE.
REQ-022 SHALL give a minimum latency of 2 cycles from ch_strobe to out_valid and a peak throughput of one byte per 2 cycles.
REQ-023 SHALL let out_ready while out_valid=0 have no effect.
REQ-024 SHALL give set priority when ovr_clr[i] and an overrun event on channel i fall in the same cycle: overrun[i] stays 1.
REQ-025 SHALL grant each of N continuously pending channels at most once per N grants (round-robin fairness).

Reset
REQ-026 SHALL, on reset_n low, asynchronously force: state IDLE; out_valid=0; out_data=0; out_ch=0; pend=0; overrun=0; all slots 0; last_grant=NCH-1, so channel 0 has first priority.
REQ-027 SHALL, on reset mid-offer, discard the offered byte and all pending bytes; the host sees out_valid fall without a handshake.

Configuration
REQ-028 SHALL, with macro RX_ARB_OVR_CNT_EN defined, add output ovr_count (8 bits) that increments by the number of bytes dropped per cycle, saturates at 255, clears only on reset, and resets to 0.
REQ-029 SHALL, without RX_ARB_OVR_CNT_EN, omit the ovr_count port and counter logic; all other behaviour is identical.

Verification
REQ-030 SHALL verify single byte: strobe ch2 with 0xA5, out_ready=1 -> out_valid at +2 cycles, out_data=0xA5, out_ch=2, pend[2] clears after handshake.
REQ-031 SHALL verify round-robin: strobe ch0..ch3 with 0x10..0x13 in the same cycle, out_ready=1 -> grants in order 0,1,2,3 on alternate cycles, no overrun.
REQ-032 SHALL verify overrun: strobe ch1 with 0x55, hold out_ready=0, then strobe ch1 with 0x66 -> overrun[1]=1, later pop returns 0x55; ovr_clr[1] clears the flag; ovr_count=1 when RX_ARB_OVR_CNT_EN is defined.
REQ-033 SHALL verify pop/strobe collision: ch0 offered, strobe ch0 with 0x77 on the handshake edge -> pend[0] stays 1, no overrun, next grant to ch0 returns 0x77 when no other channel is pending.
REQ-034 SHALL verify backpressure and reset: hold out_ready=0 for 10 cycles -> out_data and out_ch stable; then pull reset_n low mid-offer -> all outputs 0 immediately, and the first grant after release goes to the lowest pending channel.

Source files
------------

// File: rtl/rx_channel_arbiter.sv
// rtl/rx_channel_arbiter.sv - per-channel byte slots, round-robin grant to one host port; RX_ARB_OVR_CNT_EN adds ovr_count
module rx_channel_arbiter #(
  parameter int NCH = 4,
  parameter int DW  = 8
) (
  input  logic                   bclk,
  input  logic                   reset_n,
  input  logic [NCH*DW-1:0]      ch_data,
  input  logic [NCH-1:0]         ch_strobe,
  output logic [DW-1:0]          out_data,
  output logic [$clog2(NCH)-1:0] out_ch,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NCH-1:0]         pend,
  output logic [NCH-1:0]         overrun,
`ifdef RX_ARB_OVR_CNT_EN
  input  logic [NCH-1:0]         ovr_clr,
  output logic [7:0]             ovr_count
`else
  input  logic [NCH-1:0]         ovr_clr
`endif
);

  localparam int CW = $clog2(NCH);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t        state;
  logic [DW-1:0] slot [NCH];
  logic [CW-1:0] last_grant;
  logic          pop;
  logic [NCH-1:0] pop_ch;
  logic [NCH-1:0] capture;
  logic [NCH-1:0] drop;
  logic          sel_found;
  logic [CW-1:0] sel_idx;
  logic [31:0]   scan;

  // out_valid is high exactly in OFFER, so this is the handshake edge
  assign pop = out_valid & out_ready;

  // Per-channel slot decisions: a pop frees the slot in the same cycle a new byte may land
  always_comb begin
    pop_ch  = '0;
    capture = '0;
    drop    = '0;
    for (int i = 0; i < NCH; i++) begin
      pop_ch[i]  = pop && (out_ch == CW'(i));
      capture[i] = ch_strobe[i] && (!pend[i] || pop_ch[i]);
      drop[i]    = ch_strobe[i] && pend[i] && !pop_ch[i];
    end
  end

  // Round-robin scan starting one past the last granted channel, wrapping at NCH
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan      = '0;
    for (int k = 1; k <= NCH; k++) begin
      scan = 32'(last_grant) + 32'(k);
      if (scan >= 32'(NCH)) scan = scan - 32'(NCH);
      if (!sel_found && pend[scan[CW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = scan[CW-1:0];
      end
    end
  end

  // Holding slots, pending flags and sticky overrun flags (set wins over clear)
  always_ff @(posedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      pend    <= '0;
      overrun <= '0;
      for (int i = 0; i < NCH; i++) slot[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (capture[i]) begin
          slot[i] <= ch_data[i*DW +: DW];
          pend[i] <= 1'b1;
        end else if (pop_ch[i]) begin
          pend[i] <= 1'b0;
        end
        if (drop[i]) overrun[i] <= 1'b1;
        else if (ovr_clr[i]) overrun[i] <= 1'b0;
      end
    end
  end

  // Grant FSM: IDLE picks a pending channel, OFFER holds the byte until the host accepts
  always_ff @(posedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      last_grant <= CW'(NCH - 1);
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            out_data  <= slot[sel_idx];
            out_ch    <= sel_idx;
            out_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            last_grant <= out_ch;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RX_ARB_OVR_CNT_EN
  logic [3:0] n_drop;
  logic [8:0] cnt_sum;

  // Number of bytes dropped this cycle added to the running total
  always_comb begin
    n_drop = '0;
    for (int i = 0; i < NCH; i++) n_drop = n_drop + 4'(drop[i]);
    cnt_sum = {1'b0, ovr_count} + 9'(n_drop);
  end

  // Saturating drop counter, cleared only by reset
  always_ff @(posedge bclk or negedge reset_n) begin
    if (!reset_n) ovr_count <= '0;
    else ovr_count <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end
`endif

endmodule
